// File: rtl/bonus_spawner.sv
// bonus_spawner: multi-slot bonus pickup placement with lifetime, collection and spawn cooldown.
// Define BONUS_BLINK_EN to blink drawEn during the last BLINK_SECS ticks of a slot's life.
module bonus_spawner #(
  parameter int NUM_SLOTS  = 4,
  parameter int GRID_W     = 20,
  parameter int GRID_H     = 15,
  parameter int TILE_SIZE  = 32,
  parameter int PIX_OFFSET = 3,
  parameter int LIFETIME   = 15,
  parameter int COOLDOWN   = 3,
  parameter int BLINK_SECS = 3
) (
  input  logic                    clk,
  input  logic                    resetN,
  input  logic                    one_sec,
  input  logic [10:0]             matrixTopLeftX,
  input  logic [10:0]             matrixTopLeftY,
  input  logic [4:0]              inRandomX,
  input  logic [3:0]              inRandomY,
  input  logic                    randomRise,
  input  logic                    cellBlocked,
  input  logic [NUM_SLOTS-1:0]    collision,
  output logic                    newRandom,
  output logic [NUM_SLOTS*11-1:0] randomX,
  output logic [NUM_SLOTS*11-1:0] randomY,
  output logic [NUM_SLOTS-1:0]    drawEn,
  output logic [NUM_SLOTS-1:0]    collected,
  output logic [3:0]              activeCount
);
`ifdef BONUS_BLINK_EN
  localparam bit BLINK = 1'b1;
`else
  localparam bit BLINK = 1'b0;
`endif
  localparam int LW = $clog2(LIFETIME + 1);
  localparam int CW = $clog2(COOLDOWN + 2);
  logic [NUM_SLOTS-1:0] active, active_nx, vis, sel, expire;
  logic [4:0]           cell_x [NUM_SLOTS];
  logic [3:0]           cell_y [NUM_SLOTS];
  logic [LW-1:0]        life   [NUM_SLOTS];
  logic [CW-1:0]        cd;
  logic [3:0]           cnt;
  logic                 cell_ok, accept;
  always_comb begin
    logic found;
    found   = 1'b0;
    cell_ok = int'(inRandomX) < GRID_W && int'(inRandomY) < GRID_H && !cellBlocked;
    cnt     = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (active[i] && cell_x[i] == inRandomX && cell_y[i] == inRandomY) cell_ok = 1'b0;
      sel[i] = !active[i] && !found;
      found  = found | !active[i];
    end
    accept = randomRise && cell_ok && found && cd == '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      expire[i]    = one_sec && life[i] == LW'(LIFETIME - 1);
      active_nx[i] = active[i] ? !(collision[i] || expire[i]) : (accept && sel[i]);
      cnt          = cnt + 4'(active_nx[i]);
      randomX[i*11 +: 11] = 11'(int'(cell_x[i]) * TILE_SIZE + int'(matrixTopLeftX) + PIX_OFFSET);
      randomY[i*11 +: 11] = 11'(int'(cell_y[i]) * TILE_SIZE + int'(matrixTopLeftY) + PIX_OFFSET);
    end
  end
  assign drawEn = active & (vis | {NUM_SLOTS{!BLINK}});
  always_ff @(posedge clk or negedge resetN)
    if (!resetN) begin
      active      <= '0;
      vis         <= '0;
      collected   <= '0;
      newRandom   <= 1'b0;
      activeCount <= '0;
      cd          <= '0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
        cell_x[i] <= '0;
        cell_y[i] <= '0;
        life[i]   <= '0;
      end
    end else begin
      active      <= active_nx;
      collected   <= active & collision;
      newRandom   <= randomRise && !cell_ok;
      activeCount <= cnt;
      cd          <= accept ? CW'(COOLDOWN) : (one_sec && cd != '0) ? cd - CW'(1) : cd;
      for (int i = 0; i < NUM_SLOTS; i++) begin
        if (accept && sel[i]) begin
          cell_x[i] <= inRandomX;
          cell_y[i] <= inRandomY;
          life[i]   <= '0;
          vis[i]    <= 1'b1;
        end else if (active[i] && one_sec) begin
          life[i] <= life[i] + LW'(1);
          // toggling starts on the tick whose new count enters the blink window
          if (int'(life[i]) + 1 >= LIFETIME - BLINK_SECS) vis[i] <= !vis[i];
        end
      end
    end
endmodule

// File: tb/tb_bonus_spawner.sv
// tb_bonus_spawner: directed and random checks of bonus_spawner against a behavioural slot model.
module tb_bonus_spawner;
  localparam int N = 4;
  logic clk = 0, resetN = 0, one_sec = 0, randomRise = 0, cellBlocked = 0;
  logic [10:0] tlx = 0, tly = 0;
  logic [4:0] rx = 0;
  logic [3:0] ry = 0;
  logic [N-1:0] collision = 0;
  logic newRandom;
  logic [N*11-1:0] randomX, randomY;
  logic [N-1:0] drawEn, collected;
  logic [3:0] activeCount;
  int errors = 0, checks = 0;

  bonus_spawner dut (
    .clk(clk), .resetN(resetN), .one_sec(one_sec),
    .matrixTopLeftX(tlx), .matrixTopLeftY(tly),
    .inRandomX(rx), .inRandomY(ry), .randomRise(randomRise), .cellBlocked(cellBlocked),
    .collision(collision), .newRandom(newRandom), .randomX(randomX), .randomY(randomY),
    .drawEn(drawEn), .collected(collected), .activeCount(activeCount)
  );

  always #5 clk = ~clk;

  // behavioural model: slots as plain arrays, rules applied in spec order
  bit m_act[N], m_vis[N], m_new, m_ok, m_acc;
  bit [N-1:0] m_col;
  int m_x[N], m_y[N], m_life[N], m_cd, m_fr;

  initial forever begin
    @(posedge clk or negedge resetN);
    if (!resetN) begin
      m_new = 0; m_col = '0; m_cd = 0;
      for (int i = 0; i < N; i++) begin m_act[i] = 0; m_vis[i] = 0; m_x[i] = 0; m_y[i] = 0; m_life[i] = 0; end
    end else begin
      m_ok = rx < 20 && ry < 15 && !cellBlocked;
      for (int i = 0; i < N; i++) if (m_act[i] && m_x[i] == int'(rx) && m_y[i] == int'(ry)) m_ok = 0;
      m_fr = -1;
      for (int i = N - 1; i >= 0; i--) if (!m_act[i]) m_fr = i;
      m_acc = randomRise && m_ok && m_fr >= 0 && m_cd == 0;
      m_new = randomRise && !m_ok;
      for (int i = 0; i < N; i++) begin
        m_col[i] = m_act[i] && collision[i];
        if (m_act[i]) begin
          if (collision[i]) m_act[i] = 0;
          else if (one_sec) begin
            m_life[i]++;
            if (m_life[i] == 15) m_act[i] = 0;
            else if (m_life[i] >= 12) m_vis[i] = !m_vis[i];
          end
        end
      end
      if (m_acc) begin
        m_act[m_fr] = 1; m_x[m_fr] = rx; m_y[m_fr] = ry; m_life[m_fr] = 0; m_vis[m_fr] = 1; m_cd = 3;
      end else if (one_sec && m_cd > 0) m_cd--;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got=%0d want=%0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    int cnt;
    logic [10:0] ex, ey;
    cnt = 0;
    for (int i = 0; i < N; i++) cnt += int'(m_act[i]);
    chk("newRandom", int'(newRandom), int'(m_new));
    chk("activeCount", int'(activeCount), cnt);
    for (int i = 0; i < N; i++) begin
      ex = 11'(m_x[i] * 32) + tlx + 11'd3;
      ey = 11'(m_y[i] * 32) + tly + 11'd3;
`ifdef BONUS_BLINK_EN
      chk($sformatf("drawEn[%0d]", i), int'(drawEn[i]), int'(m_act[i] && m_vis[i]));
`else
      chk($sformatf("drawEn[%0d]", i), int'(drawEn[i]), int'(m_act[i]));
`endif
      chk($sformatf("collected[%0d]", i), int'(collected[i]), int'(m_col[i]));
      chk($sformatf("randomX[%0d]", i), int'(randomX[i*11 +: 11]), int'(ex));
      chk($sformatf("randomY[%0d]", i), int'(randomY[i*11 +: 11]), int'(ey));
    end
  end

  task automatic step(input bit rise, input int x, input int y, input bit blk, input bit os, input logic [N-1:0] col);
    randomRise = rise; rx = 5'(x); ry = 4'(y); cellBlocked = blk; one_sec = os; collision = col;
    @(negedge clk); #1;
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) step(0, 0, 0, 0, 1, '0);
  endtask

  initial begin
    tlx = 16; tly = 32;
    step(0, 0, 0, 0, 0, '0);
    step(0, 0, 0, 0, 0, '0);
    resetN = 1;
    chk("lit reset activeCount", int'(activeCount), 0);
    chk("lit reset drawEn", int'(drawEn), 0);
    step(1, 4, 4, 0, 0, '0);
    chk("lit spawn drawEn0", int'(drawEn[0]), 1);
    chk("lit spawn randomX0", int'(randomX[10:0]), 147);
    chk("lit spawn randomY0", int'(randomY[10:0]), 163);
    chk("lit spawn activeCount", int'(activeCount), 1);
    step(1, 25, 4, 0, 0, '0);
    chk("lit range newRandom", int'(newRandom), 1);
    chk("lit range activeCount", int'(activeCount), 1);
    step(0, 0, 0, 0, 0, '0);
    chk("lit newRandom one cycle", int'(newRandom), 0);
    step(1, 6, 6, 1, 0, '0);
    chk("lit blocked newRandom", int'(newRandom), 1);
    step(1, 4, 4, 0, 0, '0);
    chk("lit dup newRandom", int'(newRandom), 1);
    chk("lit dup activeCount", int'(activeCount), 1);
    ticks(1);
    step(1, 5, 5, 0, 0, '0);
    chk("lit cooldown1 newRandom", int'(newRandom), 0);
    chk("lit cooldown1 activeCount", int'(activeCount), 1);
    ticks(1);
    step(1, 5, 5, 0, 0, '0);
    chk("lit cooldown2 activeCount", int'(activeCount), 1);
    ticks(1);
    step(1, 5, 5, 0, 0, '0);
    chk("lit cooldown done drawEn1", int'(drawEn[1]), 1);
    chk("lit cooldown done activeCount", int'(activeCount), 2);
    ticks(11);
    chk("lit before expire activeCount", int'(activeCount), 2);
    ticks(1);
    chk("lit expire drawEn0", int'(drawEn[0]), 0);
    chk("lit expire collected", int'(collected), 0);
    chk("lit expire activeCount", int'(activeCount), 1);
    ticks(2);
    step(0, 0, 0, 0, 1, 4'b0010);
    chk("lit col+expire collected", int'(collected), 2);
    chk("lit col+expire activeCount", int'(activeCount), 0);
    chk("lit col+expire drawEn1", int'(drawEn[1]), 0);
    step(0, 0, 0, 0, 0, '0);
    chk("lit collected one cycle", int'(collected), 0);
    step(0, 0, 0, 0, 0, 4'b0100);
    chk("lit idle collision", int'(collected), 0);
    step(1, 1, 1, 0, 0, '0); ticks(3);
    step(1, 2, 2, 0, 0, '0); ticks(3);
    step(1, 3, 3, 0, 0, '0); ticks(3);
    step(1, 7, 7, 0, 0, '0); ticks(3);
    chk("lit full activeCount", int'(activeCount), 4);
    step(1, 8, 8, 0, 0, '0);
    chk("lit full drop newRandom", int'(newRandom), 0);
    chk("lit full drop activeCount", int'(activeCount), 4);
    step(1, 8, 8, 0, 0, 4'b0010);
    chk("lit free+spawn newRandom", int'(newRandom), 0);
    chk("lit free+spawn collected", int'(collected), 2);
    chk("lit free+spawn activeCount", int'(activeCount), 3);
    step(1, 8, 8, 0, 0, '0);
    chk("lit refill drawEn1", int'(drawEn[1]), 1);
    chk("lit refill activeCount", int'(activeCount), 4);
    #2 resetN = 0;
    #1;
    chk("lit async reset activeCount", int'(activeCount), 0);
    chk("lit async reset drawEn", int'(drawEn), 0);
    @(negedge clk); #1 resetN = 1;
    for (int c = 0; c < 4000; c++) begin
      int x, y;
      if ($urandom_range(0, 1) == 1) begin x = $urandom_range(0, 3); y = $urandom_range(0, 3); end
      else begin x = $urandom_range(0, 31); y = $urandom_range(0, 15); end
      if ($urandom_range(0, 49) == 0) begin tlx = 11'($urandom); tly = 11'($urandom); end
      if ($urandom_range(0, 599) == 0) resetN = 0;
      step($urandom_range(0, 2) == 0, x, y, $urandom_range(0, 7) == 0, $urandom_range(0, 4) == 0,
           $urandom_range(0, 5) == 0 ? N'($urandom) : '0);
      resetN = 1;
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/bonus_spawner.md
Name: bonus_spawner

Overview:
- Multi-slot successor to the single-bonus placement block; owns up to NUM_SLOTS simultaneous bonus pickups on the tile grid.
- Per spawn request: validates the random grid cell (range, wall, duplicate), latches it into the lowest free slot, and reports pixel coordinates and draw enables to the object drawers.
- Retires each slot on collection (collision) or after a lifetime counted in one_sec ticks.
- A global cooldown spaces successive spawns.

Parameters:
- NUM_SLOTS, 4: number of concurrent bonus slots (1..8).
- GRID_W, 20: valid X cells 0..GRID_W-1 (inRandomX width 5).
- GRID_H, 15: valid Y cells 0..GRID_H-1 (inRandomY width 4).
- TILE_SIZE, 32: pixels per cell.
- PIX_OFFSET, 3: pixel inset added to the cell origin.
- LIFETIME, 15: one_sec ticks a slot stays active (>=1).
- COOLDOWN, 3: one_sec ticks after a successful spawn before the next is accepted (0 = none).
- BLINK_SECS, 3: final ticks of the lifetime during which blinking applies (used only with the optional feature).

Ports:
- clk  in  1  system clock
- resetN  in  1  asynchronous active-low reset
- one_sec  in  1  one-cycle pulse, once per second
- matrixTopLeftX  in  11  grid origin X, pixels
- matrixTopLeftY  in  11  grid origin Y, pixels
- inRandomX  in  5  candidate cell X
- inRandomY  in  4  candidate cell Y
- randomRise  in  1  one-cycle spawn request; candidate is valid in the same cycle
- cellBlocked  in  1  map lookup of the candidate cell, combinational, same cycle; 1 = wall
- collision  in  NUM_SLOTS  per-slot hit from the collision detector
- newRandom  out  1  one-cycle pulse: candidate rejected, request a new random
- randomX  out  NUM_SLOTS*11  per-slot pixel X, slot i in bits [11i+10:11i]
- randomY  out  NUM_SLOTS*11  per-slot pixel Y, same packing
- drawEn  out  NUM_SLOTS  per-slot draw enable
- collected  out  NUM_SLOTS  one-cycle pulse per slot on pickup
- activeCount  out  4  number of active slots

Behaviour:
- Reset (async, resetN=0):
  - all slots idle; cell indices 0; life counters 0; cooldown 0.
  - drawEn=0, collected=0, newRandom=0, activeCount=0.
  - Reset mid-operation discards all slots immediately.
- Pixel coordinates: randomX_i = cellX_i*TILE_SIZE + matrixTopLeftX + PIX_OFFSET, truncated to 11 bits; Y likewise. Combinational from the latched cell; valid even while the slot is idle.
- Spawn decision, evaluated in the cycle randomRise=1. Accept only if all hold:
  - inRandomX<GRID_W and inRandomY<GRID_H;
  - cellBlocked=0;
  - no active slot holds the same (X,Y);
  - at least one idle slot exists;
  - cooldown=0.
- Accept:
  - lowest-index idle slot latches the cell, goes active, clears its life counter.
  - cooldown loads COOLDOWN.
  - drawEn for that slot is 1 from the next cycle (1-cycle latency).
- Reject: newRandom=1 on the next cycle for exactly one cycle; no state change.
  - Exception: when the only failing condition is cooldown!=0 or no idle slot, the request is dropped silently (newRandom stays 0).
- Per-slot states are IDLE and ACTIVE:
  - ACTIVE, collision_i=1: go to IDLE; collected_i pulses on the next cycle; drawEn_i=0 on the next cycle.
  - ACTIVE, one_sec=1: life counter increments. On the tick that makes it equal LIFETIME, go to IDLE (expire); no collected pulse.
  - Collision and expiring tick in the same cycle: collision wins (collected pulses).
  - collision_i while IDLE: ignored.
- Cooldown: decrements on each one_sec while non-zero and saturates at 0.
- Simultaneous free and spawn: a slot freed in cycle n cannot be filled by a randomRise in cycle n; it is available from n+1. A spawn in cycle n may use a different idle slot.
- activeCount: registered, equal to the number of ACTIVE slots.
- one_sec and randomRise in the same cycle: both take effect. The spawned slot's counter starts at 0 and does not count that tick. The cooldown loads COOLDOWN and does not decrement in that cycle.

Optional Feature:
- Macro: BONUS_BLINK_EN.
- Defined: while a slot is ACTIVE and its life counter >= LIFETIME-BLINK_SECS, drawEn_i toggles on every one_sec tick. The first toggle goes low on the tick that enters the window. drawEn_i returns to 1 on the next spawn into that slot.
- Not defined: drawEn_i = 1 for the whole ACTIVE period.

Test Plan:
- Reset, then randomRise with X=4, Y=4, cellBlocked=0, topLeft=(16,32) -> next cycle drawEn[0]=1, randomX[0]=147, randomY[0]=163, activeCount=1.
- Rejection: randomRise with X=25 (out of range) -> newRandom pulses one cycle, no slot active. Repeat with cellBlocked=1, and with the same cell as active slot 0 -> same result each time.
- COOLDOWN=3: spawn, then randomRise after 1 and after 2 one_sec ticks -> ignored, newRandom=0. After the 3rd tick, randomRise -> slot 1 spawns.
- Lifetime: spawn, apply 15 one_sec ticks -> drawEn[0] drops the cycle after the 15th tick, collected=0. With BONUS_BLINK_EN, drawEn[0] toggles at ticks 12, 13, 14.
- Collision on the same cycle as the 15th tick -> collected[0]=1 for one cycle, slot idle, activeCount decrements. collision[2] while slot 2 is idle -> no effect.
- Fill all 4 slots, then randomRise -> dropped silently. Collide slot 1 and randomRise in the same cycle -> dropped. randomRise one cycle later -> slot 1 refilled.
